// File: rtl/fetch_queue_if.sv
// Fetch-group and decode-group handshake bundle for fetch_queue.
// "slave" is the queue itself; "master" is the environment driving fetch and decode.
interface fetch_queue_if;
  logic [2:0]       in_valid;
  logic [2:0][31:0] in_inst;
  logic [2:0][31:0] in_pc;
  logic [2:0]       in_predict_valid;
  logic             in_ready;
  logic [2:0]       out_valid;
  logic [2:0][31:0] out_inst;
  logic [2:0][31:0] out_pc;
  logic [2:0]       out_predict_valid;
  logic             out_ready;

  modport slave (
    input  in_valid, in_inst, in_pc, in_predict_valid, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_predict_valid
  );

  modport master (
    output in_valid, in_inst, in_pc, in_predict_valid, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_predict_valid
  );
endinterface

// File: rtl/fetch_queue.sv
// Three-wide instruction buffer between fetch and decode: circular buffer that
// compacts sparse fetch groups and presents the three oldest entries in order.
module fetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  fetch_queue_if.slave fq
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] GROUP_W = (AW+1)'(3);

  logic [DEPTH-1:0][31:0] inst_q;
  logic [DEPTH-1:0][31:0] pc_q;
  logic [DEPTH-1:0]       pred_q;
  logic [AW-1:0]          head;
  logic [AW-1:0]          tail;
  logic [AW:0]            count;

  logic                   push_en;
  logic                   pop_en;
  logic [1:0]             push_n;
  logic [1:0]             pop_n;
  logic [2:0][1:0]        slot_off;
  logic [2:0][AW-1:0]     wr_idx;
  logic [2:0][AW-1:0]     rd_idx;

  function automatic logic [1:0] pop3(input logic [2:0] m);
    return {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
  endfunction

  // in_ready looks only at the registered count; a same-cycle pop never helps.
  assign fq.in_ready = (DEPTH_W - count) >= GROUP_W;

  always_comb begin
    push_en     = fq.in_ready & (|fq.in_valid);
    push_n      = pop3(fq.in_valid);
    slot_off[0] = 2'd0;
    slot_off[1] = {1'b0, fq.in_valid[0]};
    slot_off[2] = {1'b0, fq.in_valid[0]} + {1'b0, fq.in_valid[1]};
    for (int s = 0; s < 3; s++) begin
      wr_idx[s] = tail + AW'(slot_off[s]);
      rd_idx[s] = head + AW'(s);
    end
  end

  always_comb begin
    if (count >= GROUP_W)
      fq.out_valid = 3'b111;
    else if (count == (AW+1)'(2))
      fq.out_valid = 3'b011;
    else if (count == (AW+1)'(1))
      fq.out_valid = 3'b001;
    else
      fq.out_valid = 3'b000;

    for (int s = 0; s < 3; s++) begin
      fq.out_inst[s]          = fq.out_valid[s] ? inst_q[rd_idx[s]] : 32'd0;
      fq.out_pc[s]            = fq.out_valid[s] ? pc_q[rd_idx[s]]   : 32'd0;
      fq.out_predict_valid[s] = fq.out_valid[s] & pred_q[rd_idx[s]];
    end

    pop_en = fq.out_ready;
    pop_n  = pop3(fq.out_valid);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      inst_q <= '0;
      pc_q   <= '0;
      pred_q <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_en) begin
        for (int s = 0; s < 3; s++) begin
          if (fq.in_valid[s]) begin
            inst_q[wr_idx[s]] <= fq.in_inst[s];
            pc_q[wr_idx[s]]   <= fq.in_pc[s];
            pred_q[wr_idx[s]] <= fq.in_predict_valid[s];
          end
        end
        tail <= tail + AW'(push_n);
      end
      if (pop_en)
        head <= head + AW'(pop_n);
      count <= count
             + (AW+1)'(push_en ? push_n : 2'd0)
             - (AW+1)'(pop_en  ? pop_n  : 2'd0);
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed and random fetch/decode traffic compared each
// cycle against a queue-of-entries reference model.
module tb_fetch_queue;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic        pred;
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk;
  logic rst_n;
  logic flush;
  fetch_queue_if fq ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .fq    (fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t mq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, compare against the model, clock, update the model.
  task automatic cyc(input logic rn, input logic fl, input logic [2:0] v,
                     input logic [2:0] pr, input logic ordy,
                     input logic [31:0] ib, input logic [31:0] pcb, input bit do_chk);
    logic [2:0]       e_valid;
    logic [2:0][31:0] e_inst;
    logic [2:0][31:0] e_pc;
    logic [2:0]       e_pred;
    bit               e_rdy;
    int               npop;
    rst_n               = rn;
    flush               = fl;
    fq.in_valid         = v;
    fq.in_predict_valid = pr;
    fq.out_ready        = ordy;
    for (int i = 0; i < 3; i++) begin
      fq.in_inst[i] = ib + 32'(i);
      fq.in_pc[i]   = pcb + 32'(4 * i);
    end
    #1;
    e_rdy   = (DEPTH - mq.size()) >= 3;
    e_valid = '0;
    e_inst  = '0;
    e_pc    = '0;
    e_pred  = '0;
    for (int i = 0; i < 3; i++) begin
      if (i < mq.size()) begin
        e_valid[i] = 1'b1;
        e_inst[i]  = mq[i].inst;
        e_pc[i]    = mq[i].pc;
        e_pred[i]  = mq[i].pred;
      end
    end
    if (do_chk) begin
      chk("in_ready",  96'(fq.in_ready),          96'(e_rdy));
      chk("out_valid", 96'(fq.out_valid),         96'(e_valid));
      chk("out_inst",  96'(fq.out_inst),          96'(e_inst));
      chk("out_pc",    96'(fq.out_pc),            96'(e_pc));
      chk("out_pred",  96'(fq.out_predict_valid), 96'(e_pred));
    end
    npop = ordy ? ((mq.size() < 3) ? mq.size() : 3) : 0;
    @(posedge clk);
    if (!rn || fl) begin
      mq.delete();
    end else begin
      repeat (npop) void'(mq.pop_front());
      if (e_rdy)
        for (int s = 0; s < 3; s++)
          if (v[s]) mq.push_back('{pred: pr[s], pc: pcb + 32'(4 * s), inst: ib + 32'(s)});
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    fq.in_valid = '0; fq.in_inst = '0; fq.in_pc = '0;
    fq.in_predict_valid = '0; fq.out_ready = 1'b0;
    @(negedge clk);

    // reset held two cycles, then idle
    cyc(0, 0, 3'b000, 3'b000, 0, 32'h0, 32'h0, 0);
    cyc(0, 0, 3'b000, 3'b000, 0, 32'h0, 32'h0, 1);
    cyc(1, 0, 3'b000, 3'b000, 0, 32'h0, 32'h0, 1);

    // single full group A,B,C then one pop
    cyc(1, 0, 3'b111, 3'b010, 0, 32'hA000_0000, 32'h1c00_0000, 1);
    cyc(1, 0, 3'b000, 3'b000, 0, 32'h0, 32'h0, 1);
    cyc(1, 0, 3'b000, 3'b000, 1, 32'h0, 32'h0, 1);
    cyc(1, 0, 3'b000, 3'b000, 0, 32'h0, 32'h0, 1);

    // compaction of mask 101 with pred on slot 2
    cyc(1, 0, 3'b101, 3'b100, 0, 32'hB000_0000, 32'h2000_0000, 1);
    cyc(1, 0, 3'b000, 3'b000, 1, 32'h0, 32'h0, 1);
    cyc(1, 0, 3'b000, 3'b000, 0, 32'h0, 32'h0, 1);

    // fill to 6, third group refused, one pop reopens
    cyc(1, 0, 3'b111, 3'b001, 0, 32'hC000_0000, 32'h3000_0000, 1);
    cyc(1, 0, 3'b111, 3'b000, 0, 32'hC100_0000, 32'h3000_000c, 1);
    cyc(1, 0, 3'b111, 3'b111, 1, 32'hDEAD_0000, 32'hDEAD_0000, 1);
    cyc(1, 0, 3'b000, 3'b000, 0, 32'h0, 32'h0, 1);
    cyc(1, 0, 3'b000, 3'b000, 1, 32'h0, 32'h0, 1);
    cyc(1, 0, 3'b000, 3'b000, 1, 32'h0, 32'h0, 1);

    // random stream with wrap-around, mid-stream reset at step 25
    for (int n = 0; n < 60; n++)
      cyc((n != 25), 0, 3'($urandom_range(7)), 3'($urandom_range(7)), 1'($urandom_range(1)),
          $urandom, $urandom & 32'hffff_fffc, 1);
    for (int n = 0; n < 4; n++)
      cyc(1, 0, 3'b000, 3'b000, 1, 32'h0, 32'h0, 1);

    // flush at count 5 with simultaneous push and pop
    cyc(1, 0, 3'b111, 3'b000, 0, 32'hE000_0000, 32'h4000_0000, 1);
    cyc(1, 0, 3'b011, 3'b000, 0, 32'hE100_0000, 32'h4000_000c, 1);
    cyc(1, 1, 3'b111, 3'b111, 1, 32'hF1F1_0000, 32'h5000_0000, 1);
    for (int n = 0; n < 3; n++)
      cyc(1, 0, 3'b000, 3'b000, 1, 32'h0, 32'h0, 1);

    // traffic after flush still ordered
    for (int n = 0; n < 20; n++)
      cyc(1, 0, 3'($urandom_range(7)), 3'($urandom_range(7)), 1'($urandom_range(1)),
          $urandom, $urandom & 32'hffff_fffc, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Three-wide instruction buffer between the fetch stage and the three-wide decoder. Each cycle it accepts a fetch group of up to three instructions (with PC and branch-prediction flag) and presents the three oldest buffered instructions, in program order, on the decoder's `inst`/`pc`/`predict_valid` slots. It decouples fetch from backend stalls and drops its entire contents on a pipeline flush.

## Interface
- `DEPTH`, 8: number of entries; power of two, ≥ 4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `flush`  in  1  discard all contents; takes priority over push and pop.
- `in_valid`  in  3  per-slot valid of the fetch group; any mask is legal, including non-contiguous masks.
- `in_inst[2:0]`  in  3×32  fetched instruction words.
- `in_pc[2:0]`  in  3×32  PC of each slot.
- `in_predict_valid[2:0]`  in  3×1  BTB-predicted-taken flag of each slot.
- `in_ready`  out  1  queue can accept a full group this cycle.
- `out_valid`  out  3  decode-slot valid; always contiguous from slot 0 (000, 001, 011, 111).
- `out_inst[2:0]`  out  3×32  instructions to the decoder; slot 0 is the oldest.
- `out_pc[2:0]`  out  3×32  PCs to the decoder.
- `out_predict_valid[2:0]`  out  3×1  prediction flags to the decoder.
- `out_ready`  in  1  decoder/rename accepts every slot currently flagged in `out_valid`.

## Operation
- Storage: `DEPTH` entries of {inst[31:0], pc[31:0], pred}, a circular buffer with head/tail pointers of log2(`DEPTH`) bits and a `count` of log2(`DEPTH`)+1 bits.
- `in_ready` = (`DEPTH` − `count`) ≥ 3. It is computed from registered `count` only and ignores any pop in the same cycle.
- Push occurs when `in_ready` & |`in_valid`. Valid slots are compacted in slot order (0 → 1 → 2) into consecutive entries starting at tail, so mask 101 writes slot 0 to tail and slot 2 to tail+1. `push_n` = popcount(`in_valid`). Tail advances by `push_n` modulo `DEPTH`.
- When `in_ready` = 0, `in_valid` is ignored and nothing is written. Fetch must hold its group.
- `out_valid`: the low min(`count`, 3) bits are set. Output slot i reads entry (head+i) mod `DEPTH` combinationally.
- Output data of slots whose `out_valid` bit is 0 is driven to 0.
- Pop occurs when `out_ready`. `pop_n` = popcount(`out_valid`). Head advances by `pop_n` modulo `DEPTH`. Partial acceptance does not exist.
- Each cycle: `count` ← `count` + `push_n` − `pop_n`. Simultaneous push and pop are both applied. Entry contents are not cleared on pop.
- Flush: head, tail and count go to 0 next cycle. Same-cycle push and pop are discarded. Entry contents are left unchanged and are unobservable.
- Reset (`rst_n` = 0 at the edge): head, tail and count go to 0, and all entry fields are cleared to 0. Reset overrides flush, push and pop, including when it is asserted mid-stream.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 000, all `out_*` data = 0.
- Push-to-output latency is 1 cycle: a group pushed at edge N is visible on `out_*` after edge N, and can be popped in the same cycle it appears.
- No combinational path from `in_*` to `out_*`: no bypass when empty.
- `out_ready` affects `count` only at the next edge. It has no combinational effect on `in_ready` or `out_*`.
- Full boundary: with `count` = `DEPTH` − 2, `in_ready` = 0 even if `out_ready` = 1 this cycle.
- Wrap-around: a push or pop spanning entry `DEPTH` − 1 → 0 must keep program order.
- The first cycle after flush shows `out_valid` = 000 and `in_ready` = 1.

## Test plan
- Reset then idle: hold `rst_n` = 0 for 2 cycles and release -> `in_ready` = 1, `out_valid` = 000, all `out_*` = 0.
- Single full group: push {A,B,C} with pc 0x1c000000/04/08, `out_ready` = 0 -> next cycle `out_valid` = 111 in order A, B, C. Assert `out_ready` for 1 cycle -> `out_valid` = 000.
- Compaction: push `in_valid` = 101 {X,–,Z} with `in_predict_valid` = 100 -> `out_valid` = 011, slot 0 = X (pred 0), slot 1 = Z (pred 1).
- Fill and backpressure with DEPTH = 8, `out_ready` = 0:
  - Push 3, 3 -> count 6, `in_ready` = 0, and the 3rd group is not written.
  - Pop with `out_ready` = 1 for 1 cycle -> count 3, `in_ready` = 1.
- Wrap with simultaneous push and pop: stream 20 groups of random masks with random `out_ready` -> the output sequence equals the compacted input sequence, with no loss, duplication or reordering across index 7 → 0.
- Flush priority: at count 5, assert `flush` together with push 111 and `out_ready` -> next cycle count 0, `out_valid` = 000, and none of the pushed instructions ever appear on the output.
